// File: rtl/instr_fetch_buffer_pkg.sv
// Shared types and constants for the instruction fetch buffer.
//   fetch_state_t : LOAD (collecting bytes) / HOLD (instruction presented)
//   OPC_*         : MIPS opcode values seen by downstream control
//   INSTR_BYTES   : bytes per instruction on the byte stream
package instr_fetch_buffer_pkg;

  typedef enum logic {
    LOAD = 1'b0,
    HOLD = 1'b1
  } fetch_state_t;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;
  localparam logic [5:0] OPC_BEQ   = 6'h04;

  localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/instr_fetch_buffer_pc_next_calc.sv
// Next-PC calculator (combinational).
//   pc      in  PC_W  current instruction address
//   imm     in  16    branch immediate (word offset, signed)
//   branch  in  1     branch instruction indicator from control
//   zero    in  1     ALU zero flag
//   next_pc out PC_W  pc + 4, or pc + 4 + (sext(imm) << 2) when branch & zero
module pc_next_calc #(
  parameter int PC_W = 8
) (
  input  logic [PC_W-1:0] pc,
  input  logic [15:0]     imm,
  input  logic            branch,
  input  logic            zero,
  output logic [PC_W-1:0] next_pc
);

  // Offset built at 32 bits, then truncated; PC wraps modulo 2^PC_W.
  logic [31:0]     w_offset;
  logic [PC_W-1:0] w_step;

  assign w_offset = {{14{imm[15]}}, imm, 2'b00};
  assign w_step   = (branch & zero) ? (w_offset[PC_W-1:0] + PC_W'(4)) : PC_W'(4);
  assign next_pc  = pc + w_step;

endmodule

// File: rtl/instr_fetch_buffer.sv
// Instruction fetch buffer: assembles a 32-bit MIPS instruction from four
// bytes (MSB first), presents its decoded fields, and advances the PC when
// the consumer retires the instruction.
//   clk, rst (async, active-high)
//   byte_in/byte_valid/byte_ready : byte stream in
//   flush                         : drop partial load / held instruction
//   instr_ack, branch, zero       : retire held instruction, select next PC
//   instr_valid, opcode..imm      : held instruction and its fields
//   pc, retired                   : instruction address, retire count
//
// state | meaning
// LOAD  | accepting bytes, byte_ready=1, fields show partial contents
// HOLD  | full instruction held, instr_valid=1, waiting for instr_ack
module instr_fetch_buffer
  import instr_fetch_buffer_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      byte_in,
  input  logic            byte_valid,
  output logic            byte_ready,
  input  logic            flush,
  input  logic            instr_ack,
  input  logic            branch,
  input  logic            zero,
  output logic            instr_valid,
  output logic [5:0]      opcode,
  output logic [4:0]      rs,
  output logic [4:0]      rt,
  output logic [4:0]      rd,
  output logic [5:0]      funct,
  output logic [15:0]     imm,
  output logic [PC_W-1:0] pc,
  output logic [7:0]      retired
);

  localparam logic [1:0] LAST_BYTE = 2'(INSTR_BYTES - 1);

  fetch_state_t    r_state;
  fetch_state_t    w_state_nxt;
  logic [1:0]      r_count;
  logic [31:0]     r_instr;
  logic [PC_W-1:0] r_pc;
  logic [7:0]      r_retired;
  logic            w_shift;
  logic            w_retire;
  logic [PC_W-1:0] w_next_pc;

  pc_next_calc #(.PC_W(PC_W)) u_pc_next (
    .pc      (r_pc),
    .imm     (r_instr[15:0]),
    .branch  (branch),
    .zero    (zero),
    .next_pc (w_next_pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= LOAD;
      r_count   <= 2'd0;
      r_instr   <= 32'd0;
      r_pc      <= '0;
      r_retired <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      if (flush) begin
        r_count <= 2'd0;
        r_instr <= 32'd0;
      end else if (w_shift) begin
        r_instr <= {r_instr[23:0], byte_in};
        r_count <= r_count + 2'd1;  // wraps to 0 on the last byte
      end
      if (w_retire) begin
        r_pc      <= w_next_pc;
        r_retired <= r_retired + 8'd1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift     = 1'b0;
    w_retire    = 1'b0;
    byte_ready  = 1'b0;
    instr_valid = 1'b0;
    case (r_state)
      LOAD: begin
        // Held low while rst is asserted so every output reads zero in reset.
        byte_ready = ~rst;
        w_shift    = byte_valid;
        if (byte_valid && (r_count == LAST_BYTE)) w_state_nxt = HOLD;
      end
      HOLD: begin
        instr_valid = 1'b1;
        if (instr_ack) begin
          w_retire    = 1'b1;
          w_state_nxt = LOAD;
        end
      end
      default: w_state_nxt = LOAD;
    endcase
    if (flush) begin
      w_state_nxt = LOAD;
      w_shift     = 1'b0;
      w_retire    = 1'b0;
    end
  end

  assign opcode  = r_instr[31:26];
  assign rs      = r_instr[25:21];
  assign rt      = r_instr[20:16];
  assign rd      = r_instr[15:11];
  assign funct   = r_instr[5:0];
  assign imm     = r_instr[15:0];
  assign pc      = r_pc;
  assign retired = r_retired;

endmodule

// File: tb/tb_instr_fetch_buffer.sv
module tb_instr_fetch_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        flush = 1'b0;
  logic        instr_ack = 1'b0;
  logic        branch = 1'b0;
  logic        zero = 1'b0;
  logic        instr_valid;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [7:0]  pc;
  logic [7:0]  retired;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  instr_fetch_buffer #(.PC_W(8)) dut (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .flush(flush), .instr_ack(instr_ack),
    .branch(branch), .zero(zero), .instr_valid(instr_valid),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .funct(funct),
    .imm(imm), .pc(pc), .retired(retired)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_in = b;
    byte_valid = 1'b1;
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic send4(input logic [7:0] b0, b1, b2, b3);
    send_byte(b0); send_byte(b1); send_byte(b2); send_byte(b3);
  endtask

  task automatic do_ack(input logic br, input logic z);
    instr_ack = 1'b1; branch = br; zero = z;
    tick();
    instr_ack = 1'b0; branch = 1'b0; zero = 1'b0;
  endtask

  task automatic test_reset();
    #12 rst = 1'b0;
    tick();
    n_vec++; if (byte_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", byte_ready); end
    n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", instr_valid); end
    n_vec++; if (pc !== 8'd0 || retired !== 8'd0) begin n_err++; $display("FAIL reset_pc_ret got %h/%h want 00/00", pc, retired); end
    send_byte(8'h8C); send_byte(8'h22);
    n_vec++; if (imm !== 16'h8C22) begin n_err++; $display("FAIL partial_imm got %h want 8c22", imm); end
    #3 rst = 1'b1;
    #1;
    n_vec++; if (imm !== 16'h0000 || byte_ready !== 1'b0 || instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_async got imm=%h rdy=%b vld=%b want 0000/0/0", imm, byte_ready, instr_valid); end
    @(negedge clk) rst = 1'b0;
    tick();
    n_vec++; if (byte_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready got %b want 1", byte_ready); end
  endtask

  task automatic test_rtype();
    send_byte(8'h00); send_byte(8'h22); send_byte(8'h18);
    n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rtype_early_valid got %b want 0", instr_valid); end
    send_byte(8'h20);
    n_vec++; if (instr_valid !== 1'b1 || byte_ready !== 1'b0) begin n_err++; $display("FAIL rtype_valid got vld=%b rdy=%b want 1/0", instr_valid, byte_ready); end
    n_vec++; if ({opcode, rs, rt, rd, funct} !== {6'h00, 5'd1, 5'd2, 5'd3, 6'h20}) begin n_err++; $display("FAIL rtype_fields got op=%h rs=%0d rt=%0d rd=%0d fn=%h want 00/1/2/3/20", opcode, rs, rt, rd, funct); end
    n_vec++; if (pc !== 8'd0) begin n_err++; $display("FAIL rtype_pc_before got %0d want 0", pc); end
    do_ack(1'b0, 1'b1);
    n_vec++; if (pc !== 8'd4 || retired !== 8'd1 || instr_valid !== 1'b0) begin n_err++; $display("FAIL rtype_ack got pc=%0d ret=%0d vld=%b want 4/1/0", pc, retired, instr_valid); end
  endtask

  task automatic test_lw();
    send4(8'h8C, 8'h22, 8'h00, 8'h04);
    n_vec++; if (opcode !== 6'h23 || imm !== 16'h0004 || rt !== 5'd2) begin n_err++; $display("FAIL lw_fields got op=%h imm=%h rt=%0d want 23/0004/2", opcode, imm, rt); end
    do_ack(1'b0, 1'b0);
    n_vec++; if (pc !== 8'd8 || retired !== 8'd2) begin n_err++; $display("FAIL lw_ack got pc=%0d ret=%0d want 8/2", pc, retired); end
  endtask

  task automatic test_beq();
    send4(8'h10, 8'h22, 8'hFF, 8'hFF);
    n_vec++; if (opcode !== 6'h04 || imm !== 16'hFFFF) begin n_err++; $display("FAIL beq_fields got op=%h imm=%h want 04/ffff", opcode, imm); end
    do_ack(1'b1, 1'b1);
    n_vec++; if (pc !== 8'd8 || retired !== 8'd3) begin n_err++; $display("FAIL beq_taken got pc=%0d ret=%0d want 8/3", pc, retired); end
    send4(8'h10, 8'h22, 8'hFF, 8'hFF);
    do_ack(1'b1, 1'b0);
    n_vec++; if (pc !== 8'd12 || retired !== 8'd4) begin n_err++; $display("FAIL beq_not_taken got pc=%0d ret=%0d want 12/4", pc, retired); end
  endtask

  task automatic test_back_to_back();
    send4(8'h8C, 8'h22, 8'h00, 8'h04);
    byte_in = 8'hAA; byte_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_vec++; if (byte_ready !== 1'b0 || imm !== 16'h0004 || opcode !== 6'h23) begin n_err++; $display("FAIL bp_hold cyc=%0d got rdy=%b op=%h imm=%h want 0/23/0004", i, byte_ready, opcode, imm); end
    end
    instr_ack = 1'b1;
    tick();
    instr_ack = 1'b0;
    n_vec++; if (pc !== 8'd16 || retired !== 8'd5 || byte_ready !== 1'b1) begin n_err++; $display("FAIL bp_ack got pc=%0d ret=%0d rdy=%b want 16/5/1", pc, retired, byte_ready); end
    for (int i = 0; i < 4; i++) tick();
    byte_valid = 1'b0;
    n_vec++; if (instr_valid !== 1'b1 || opcode !== 6'h2A || imm !== 16'hAAAA) begin n_err++; $display("FAIL bp_next got vld=%b op=%h imm=%h want 1/2a/aaaa", instr_valid, opcode, imm); end
    do_ack(1'b0, 1'b0);
    n_vec++; if (pc !== 8'd20 || retired !== 8'd6) begin n_err++; $display("FAIL bp_next_ack got pc=%0d ret=%0d want 20/6", pc, retired); end
  endtask

  task automatic test_flush();
    send_byte(8'h12); send_byte(8'h34);
    flush = 1'b1; byte_in = 8'h56; byte_valid = 1'b1;
    tick();
    flush = 1'b0; byte_valid = 1'b0;
    n_vec++; if (instr_valid !== 1'b0 || imm !== 16'h0000 || pc !== 8'd20) begin n_err++; $display("FAIL flush_load got vld=%b imm=%h pc=%0d want 0/0000/20", instr_valid, imm, pc); end
    do_ack(1'b1, 1'b1);
    n_vec++; if (pc !== 8'd20 || retired !== 8'd6) begin n_err++; $display("FAIL ack_in_load got pc=%0d ret=%0d want 20/6", pc, retired); end
    send_byte(8'h00); send_byte(8'h22); send_byte(8'h18);
    n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL flush_count got vld=%b want 0", instr_valid); end
    send_byte(8'h20);
    n_vec++; if (instr_valid !== 1'b1 || rd !== 5'd3 || funct !== 6'h20) begin n_err++; $display("FAIL flush_reload got vld=%b rd=%0d fn=%h want 1/3/20", instr_valid, rd, funct); end
    flush = 1'b1; instr_ack = 1'b1; byte_in = 8'h77; byte_valid = 1'b1;
    tick();
    flush = 1'b0; instr_ack = 1'b0; byte_valid = 1'b0;
    n_vec++; if (instr_valid !== 1'b0 || pc !== 8'd20 || retired !== 8'd6 || funct !== 6'h00) begin n_err++; $display("FAIL flush_ack got vld=%b pc=%0d ret=%0d fn=%h want 0/20/6/00", instr_valid, pc, retired, funct); end
    n_vec++; if (byte_ready !== 1'b1) begin n_err++; $display("FAIL flush_ready got %b want 1", byte_ready); end
  endtask

  task automatic test_reset_hold();
    send4(8'h8C, 8'h22, 8'h00, 8'h04);
    #3 rst = 1'b1;
    #1;
    n_vec++; if (pc !== 8'd0 || retired !== 8'd0 || instr_valid !== 1'b0 || opcode !== 6'h00) begin n_err++; $display("FAIL reset_hold got pc=%0d ret=%0d vld=%b op=%h want 0/0/0/00", pc, retired, instr_valid, opcode); end
    @(negedge clk) rst = 1'b0;
    tick();
    n_vec++; if (byte_ready !== 1'b1) begin n_err++; $display("FAIL reset_hold_ready got %b want 1", byte_ready); end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw();
    test_beq();
    test_back_to_back();
    test_flush();
    test_reset_hold();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
